rsa_decrypt: RTL and testbench
==============================

# rsa_decrypt

Sequential RSA decryption engine: computes plain = cipher^d mod n by right-to-left square-and-multiply over a 6-bit modulus. It is the receive end of the team's 6-bit RSA datapath and sits downstream of the encryptor. Each modular multiply is reduced in an iterative shift-subtract reducer, not a lookup memory. A start/done handshake frames one decryption per request.

## Interface
- WIDTH, 6: operand/modulus width in bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- cipher  input  WIDTH  ciphertext; latched on accepted start.
- d_key  input  WIDTH  private exponent d; latched on accepted start.
- n  input  WIDTH  modulus; latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until done rises.
- done  output  1  level; high while result is valid, until the next accepted start.
- err  output  1  valid with done; high when latched n < 2.
- plain  output  WIDTH  decrypted result; holds value while done is high.

## Operation
- Reset values: busy=0, done=0, err=0, plain=0. FSM returns to IDLE. Internal registers are cleared.
- States and transitions:
  - IDLE/DONE --start--> LOAD.
  - LOAD: if n<2, go to DONE with err=1 and plain=0. Otherwise issue modmul(cipher,1) and go to WAIT_BASE.
  - WAIT_BASE: on reducer done, base := result, acc := 1, e := d_key. Then go to CHECK.
  - CHECK: if e==0, go to DONE with plain := acc. Else if e[0], issue modmul(acc,base) and go to WAIT_MUL. Else issue modmul(base,base) and go to WAIT_SQ.
  - WAIT_MUL: on reducer done, acc := result. Issue modmul(base,base) and go to WAIT_SQ.
  - WAIT_SQ: on reducer done, base := result and e := e>>1. Go to CHECK.
- Squaring is performed for every exponent bit, including the MSB. No skip optimisation.
- Product is 2*WIDTH bits, unsigned, formed combinationally from the two registered operands.
- Reduction is a restoring remainder over the 2*WIDTH-bit product. Each step is one cycle, shifting one product bit MSB-first into a WIDTH+1-bit partial remainder and subtracting n when partial ≥ n. Result is always < n.
- cipher ≥ n is legal and is reduced by the initial modmul.
- start while busy is ignored and has no effect on latched operands.
- rst mid-operation aborts immediately. No partial result is visible.
- Input changes after acceptance are ignored.

## Timing
- Reducer latency: L = 2*WIDTH+1 = 13 cycles from its start pulse to its done pulse (1 load + 12 steps).
- Each modmul occupies L+1 = 14 cycles including the issue cycle.
- Total latency: done rises (1+B+P)*(L+1)+1 cycles after the start edge.
  - B = bit length of d (index of MSB + 1; 0 when d=0).
  - P = popcount(d).
- n<2 case: done and err rise 2 cycles after start.
- busy and done are never high together.
- done falls on the cycle after a new accepted start, when busy rises.

## Structure
- Shared package rsa_pkg holds:
  - WIDTH default.
  - State enum: IDLE, LOAD, WAIT_BASE, CHECK, WAIT_MUL, WAIT_SQ, DONE.
  - Product width constant 2*WIDTH.
- One sub-module, mod_reduce_seq, with ports clk, rst, start, prod[2*WIDTH-1:0], n, done, rem. It is the shift-subtract reducer and is reusable by the encryptor.
- Top holds the FSM, the acc/base/e registers and the combinational multiplier.

## Test plan
- n=33, d=3, cipher=16 -> plain=4, err=0; done at cycle 71 after start (5 modmuls).
- n=55, d=27, cipher=8 -> plain=2; done at cycle 141 (B=5, P=4).
- n=33, d=3, cipher=49 (≥n) -> plain=4; same latency as the first scenario.
- d=0, n=33, cipher=20 -> plain=1 at cycle 15. Then n=1 -> err=1, plain=0 at cycle 2.
- start pulsed again at cycle 30 of the first case with different operands -> ignored; result still 4 at cycle 71. A new start in DONE clears done next cycle.
- rst asserted at cycle 40 mid-run -> busy=0, done=0, plain=0 immediately. A fresh start afterwards completes correctly.

Source files
------------

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared widths and FSM state codes for the 6-bit RSA datapath
package rsa_pkg;
    localparam int WIDTH  = 6;
    localparam int PROD_W = 2 * WIDTH;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_WAIT_BASE = 3'd2;
    localparam logic [2:0] ST_CHECK     = 3'd3;
    localparam logic [2:0] ST_WAIT_MUL  = 3'd4;
    localparam logic [2:0] ST_WAIT_SQ   = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
endpackage

// File: rtl/mod_reduce_seq.sv
// rtl/mod_reduce_seq.sv - restoring shift-subtract reducer: rem = prod mod n, one product bit per cycle
module mod_reduce_seq #(
    parameter int W = rsa_pkg::WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] prod,
    input  logic [W-1:0]   n,
    output logic           done,
    output logic [W-1:0]   rem
);
    localparam int CW = $clog2(2 * W + 1);
    localparam logic [CW-1:0] STEPS = CW'(2 * W);

    logic [2*W-1:0] p;
    logic [W-1:0]   nn;
    logic [CW-1:0]  cnt;
    logic           active;

    // rem < n always holds, so the shifted trial fits in W+1 bits and one subtract restores it
    logic [W:0] trial;
    logic [W:0] n_ext;
    logic [W:0] diff;
    logic [W-1:0] rem_next;

    assign trial    = {rem, p[2*W-1]};
    assign n_ext    = {1'b0, nn};
    assign diff     = trial - n_ext;
    assign rem_next = (trial >= n_ext) ? diff[W-1:0] : trial[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= '0;
            nn     <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                p      <= prod;
                nn     <= n;
                rem    <= '0;
                cnt    <= STEPS;
                active <= 1'b1;
            end else if (active) begin
                rem <= rem_next;
                p   <= {p[2*W-2:0], 1'b0};
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/rsa_decrypt.sv
// rtl/rsa_decrypt.sv - plain = cipher^d mod n by right-to-left square-and-multiply
module rsa_decrypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = rsa_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cipher,
    input  logic [WIDTH-1:0] d_key,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] plain
);
    localparam int PW = 2 * WIDTH;

    logic [2:0]       state;
    logic [WIDTH-1:0] cipher_r, d_r, n_r;
    logic [WIDTH-1:0] acc, base, e;
    logic             sq_issue;
    logic             err_r, done_r;
    logic [WIDTH-1:0] plain_r;

    logic [WIDTH-1:0] op_a, op_b;
    logic             red_start, red_done;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] red_rem;

    always_comb begin
        op_a      = base;
        op_b      = base;
        red_start = 1'b0;
        case (state)
            ST_LOAD: begin
                op_a      = cipher_r;
                op_b      = WIDTH'(1);
                red_start = (n_r >= WIDTH'(2));
            end
            ST_CHECK: begin
                if (e[0]) op_a = acc;
                red_start = (e != '0);
            end
            ST_WAIT_SQ: red_start = sq_issue;
            default: ;
        endcase
    end

    assign prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};

    mod_reduce_seq #(.W(WIDTH)) u_reduce (
        .clk   (clk),
        .rst   (rst),
        .start (red_start),
        .prod  (prod),
        .n     (n_r),
        .done  (red_done),
        .rem   (red_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cipher_r <= '0;
            d_r      <= '0;
            n_r      <= '0;
            acc      <= '0;
            base     <= '0;
            e        <= '0;
            sq_issue <= 1'b0;
            err_r    <= 1'b0;
            done_r   <= 1'b0;
            plain_r  <= '0;
        end else begin
            sq_issue <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cipher_r <= cipher;
                        d_r      <= d_key;
                        n_r      <= n;
                        done_r   <= 1'b0;
                        err_r    <= 1'b0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // degenerate modulus drains through CHECK with e=0 so plain=0 one cycle later
                    if (n_r < WIDTH'(2)) begin
                        err_r <= 1'b1;
                        acc   <= '0;
                        e     <= '0;
                        state <= ST_CHECK;
                    end else begin
                        state <= ST_WAIT_BASE;
                    end
                end
                ST_WAIT_BASE: begin
                    if (red_done) begin
                        base  <= red_rem;
                        acc   <= WIDTH'(1);
                        e     <= d_r;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (e == '0) begin
                        plain_r <= acc;
                        done_r  <= 1'b1;
                        state   <= ST_DONE;
                    end else if (e[0]) begin
                        state <= ST_WAIT_MUL;
                    end else begin
                        state <= ST_WAIT_SQ;
                    end
                end
                ST_WAIT_MUL: begin
                    // squaring is issued on the following cycle to keep every modmul at a fixed slot length
                    if (red_done) begin
                        acc      <= red_rem;
                        sq_issue <= 1'b1;
                        state    <= ST_WAIT_SQ;
                    end
                end
                ST_WAIT_SQ: begin
                    if (red_done) begin
                        base  <= red_rem;
                        e     <= e >> 1;
                        state <= ST_CHECK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (state != ST_IDLE) && (state != ST_DONE);
    assign done  = done_r;
    assign err   = err_r & done_r;
    assign plain = plain_r;
endmodule

// File: tb/tb_rsa_decrypt.sv
// tb/tb_rsa_decrypt.sv - directed self-checking bench for rsa_decrypt against an arithmetic model
module tb_rsa_decrypt;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] cipher = '0;
    logic [5:0] d_key = '0;
    logic [5:0] n = '0;
    logic       busy, done, err;
    logic [5:0] plain;

    int checks = 0;
    int failures = 0;

    logic       exp_valid = 1'b0;
    logic [5:0] exp_plain = '0;
    logic       exp_err = 1'b0;

    rsa_decrypt dut (
        .clk(clk), .rst(rst), .start(start), .cipher(cipher), .d_key(d_key), .n(n),
        .busy(busy), .done(done), .err(err), .plain(plain)
    );

    always #5 clk = ~clk;

    function automatic int modexp(input int c, input int d, input int m);
        int r, b;
        if (m < 2) return 0;
        r = 1;
        b = c % m;
        for (int i = 0; i < 6; i++) begin
            if (((d >> i) & 1) == 1) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    function automatic int latency(input int d, input int m);
        int bl, pc;
        if (m < 2) return 2;
        bl = 0;
        pc = 0;
        for (int i = 0; i < 6; i++) begin
            if (((d >> i) & 1) == 1) begin
                bl = i + 1;
                pc++;
            end
        end
        return (1 + bl + pc) * 14 + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_exclusive", int'(busy && done), 0);
            if (done && exp_valid) begin
                check("cmp_plain", int'(plain), int'(exp_plain));
                check("cmp_err", int'(err), int'(exp_err));
            end
        end
    end

    task automatic run(input int c, input int dk, input int nn, input int lit_plain,
                       input int lit_lat, input int lit_err, input int ignore_at, input int rst_at);
        bit seen;
        int k;
        @(negedge clk);
        cipher = 6'(c);
        d_key  = 6'(dk);
        n      = 6'(nn);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_plain = 6'(modexp(c, dk, nn));
        exp_err   = (nn < 2);
        exp_valid = 1'b1;
        check("accept_busy", int'(busy), 1);
        check("accept_done_clear", int'(done), 0);
        seen = 0;
        k = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                k = i;
                break;
            end
            if (i == rst_at) begin
                exp_valid = 1'b0;
                rst = 1'b1;
                #1;
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_plain", int'(plain), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (i == ignore_at - 1) begin
                cipher = 6'd7;
                d_key  = 6'd5;
                n      = 6'd55;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency_model", k, latency(dk, nn));
            check("latency_lit", k, lit_lat);
            check("plain_lit", int'(plain), lit_plain);
            check("err_lit", int'(err), lit_err);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_plain", int'(plain), 0);
        @(negedge clk);
        rst = 1'b0;

        check("model_pin_a", modexp(16, 3, 33), 4);
        check("model_pin_b", modexp(8, 27, 55), 2);

        run(16, 3, 33, 4, 71, 0, 0, 0);
        run(8, 27, 55, 2, 141, 0, 0, 0);
        run(49, 3, 33, 4, 71, 0, 0, 0);
        run(20, 0, 33, 1, 15, 0, 0, 0);
        run(20, 0, 1, 0, 2, 1, 0, 0);
        run(20, 5, 0, 0, 2, 1, 0, 0);
        run(16, 3, 33, 4, 71, 0, 30, 0);
        run(16, 27, 55, 0, 0, 0, 0, 40);
        run(8, 27, 55, 2, 141, 0, 0, 0);
        run(5, 63, 63, modexp(5, 63, 63), latency(63, 63), 0, 0, 0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
